fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Drains bytes from the read side of the 8-deep byte FIFO and sends each as a UART frame.
//  Frame format is 8N1: start bit, 8 data bits LSB first, 1 stop bit.
//  Sits between the FIFO's rd/rdata/empty port and the board TX pin.
//  This is the consumer that completes the FIFO-based transmit path.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk cycles per UART bit (100 MHz / 9600 baud); must be >= 2
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  fifo_empty  in   1  FIFO empty flag; 1 = no data
//  fifo_rdata  in   8  FIFO head byte; valid in the same cycle while fifo_empty=0 (show-ahead)
//  fifo_rd     out  1  pop strobe to FIFO; exactly 1 cycle per byte consumed
//  tx          out  1  serial line; idles high
//  tx_busy     out  1  1 from the first start-bit cycle through the last stop-bit cycle
//  tx_done     out  1  1-cycle pulse on the last cycle of each stop bit
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE; baud counter, bit counter and shift register all 0.
//   - tx=1, tx_busy=0, tx_done=0, fifo_rd=0.
//   - Any frame in progress is aborted and its byte is lost; tx returns to 1 immediately.
//  FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//  IDLE:
//   - fifo_rd = (state==IDLE) & ~fifo_empty (combinational).
//   - In that cycle fifo_rdata is latched into the shift register, and state <= START.
//   - fifo_rd is never asserted while fifo_empty=1 or outside IDLE.
//  START: tx=0 for CLKS_PER_BIT cycles.
//  DATA:
//   - 8 bits sent LSB first, each held CLKS_PER_BIT cycles.
//   - Shift register shifts right at each bit boundary.
//   - 3-bit bit counter; leave DATA after bit index 7.
//  STOP:
//   - tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the final cycle.
//   - Then state <= IDLE.
//  Timing:
//   - tx is registered and changes only on bit boundaries.
//   - tx falls on the clk edge that ends the fifo_rd cycle.
//   - Frame length is exactly 10*CLKS_PER_BIT cycles.
//  Baud counter:
//   - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit boundary.
//   - Cleared on entry to START.
//  Back-to-back frames:
//   - If the FIFO is still non-empty after STOP, there is exactly one IDLE cycle (the pop cycle).
//   - The next start bit follows it; tx stays 1 during that cycle.
//  Byte capture: fifo_rdata is sampled only in the pop cycle. Later FIFO writes never alter a frame in flight.
//  tx_busy = (state != IDLE); it is registered through the state register.
// TESTING (sim with CLKS_PER_BIT=4)
//  1. Reset, fifo_empty=1 held 50 cycles -> tx=1, fifo_rd=0, tx_busy=0 throughout.
//  2. One byte 0x55, empty deasserts once -> one fifo_rd pulse; tx = 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit;
//     tx_done pulse at cycle 40 after the pop.
//  3. Three bytes 0xA5,0x00,0xFF queued -> 3 fifo_rd pulses 41 cycles apart;
//     decoded bytes match in order; 1-cycle idle gaps.
//  4. Change fifo_rdata mid-frame (without popping) -> the transmitted byte is the one sampled at the pop.
//  5. rst_n low during data bit 3 of 0xC3 -> tx=1 and tx_busy=0 asynchronously;
//     after release no stray fifo_rd while empty=1.
//  6. Assertion: fifo_rd never high when fifo_empty=1 or tx_busy=1; tx_done only in STOP.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead byte FIFO and sends each one
// as an 8N1 UART frame (start bit, 8 data bits LSB first, 1 stop bit).
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   fifo_empty  FIFO empty flag (1 = no data)
//   fifo_rdata  FIFO head byte, valid while fifo_empty = 0
//   fifo_rd     1-cycle pop strobe, one per byte taken
//   tx          serial line, idles high
//   tx_busy     high from the first start-bit cycle to the last stop-bit cycle
//   tx_done     1-cycle pulse on the last cycle of each stop bit
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          pop;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        tx_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Counter held at zero so START always begins a fresh bit.
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Next bit is shreg_q[1] before the shift lands.
                        tx_d    = shreg_q[1];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // No pop may escape while reset is held, even if the FIFO has data.
    assign fifo_rd = pop & rst_n;
    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule
